uart_sdram_cmd_bridge: RTL

//   Converts an ASCII-hex command stream from the UART into SDRAM controller commands.
//   It formats read results back to the UART as ASCII-hex. It sits between uart (rx/tx)
//   and SDRAMController and replaces inline top-level parsing logic.

---
 rtl/uart_sdram_cmd_bridge_if.sv | 29 ++
 rtl/uart_sdram_cmd_bridge.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/uart_sdram_cmd_bridge_if.sv
// Handshake and data signals between the UART/SDRAM side and the command bridge.
// The bridge uses the master view; the UART/controller side uses the slave view.
interface uart_sdram_cmd_bridge_if #(
    parameter int AddrWidth = 16,
    parameter int DataWidth = 8
);
    logic                 rxValid;
    logic [7:0]           rxByte;
    logic                 txBusy;
    logic                 txTrigger;
    logic [7:0]           txByte;
    logic                 cmdReady;
    logic                 cmdTrigger;
    logic [AddrWidth-1:0] cmdAddr;
    logic                 cmdWrite;
    logic [DataWidth-1:0] cmdWriteData;
    logic [DataWidth-1:0] cmdReadData;
    logic                 cmdReadDataValid;

    modport master (
        input  rxValid, rxByte, txBusy, cmdReady, cmdReadData, cmdReadDataValid,
        output txTrigger, txByte, cmdTrigger, cmdAddr, cmdWrite, cmdWriteData
    );

    modport slave (
        output rxValid, rxByte, txBusy, cmdReady, cmdReadData, cmdReadDataValid,
        input  txTrigger, txByte, cmdTrigger, cmdAddr, cmdWrite, cmdWriteData
    );
endinterface

// File: rtl/uart_sdram_cmd_bridge.sv
// Parses ASCII-hex w/r/d commands from the UART into single SDRAM commands and
// returns read data as lowercase ASCII-hex, echoing every accepted byte.
//
// state   | meaning
// --------+-----------------------------------------------------------
// S_IDLE  | waiting for a command letter (w, r, d)
// S_ADDR  | collecting AddrWidth/4 address digits
// S_DATA  | collecting the two write-data digits
// S_COUNT | collecting the two dump-count digits (00 = 256)
// S_EXEC  | command presented on cmd*, held until cmdReady
// S_WAIT  | read accepted, waiting for cmdReadDataValid
module uart_sdram_cmd_bridge #(
    parameter int AddrWidth = 16,
    parameter int DataWidth = 8
) (
    input  logic                   clk,
    input  logic                   rst,
    uart_sdram_cmd_bridge_if.master bus
);
    localparam int NumDigits = AddrWidth / 4;
    localparam int DigW      = $clog2(NumDigits + 1);
    localparam logic [DigW-1:0] LastDigit = DigW'(NumDigits - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ADDR,
        S_DATA,
        S_COUNT,
        S_EXEC,
        S_WAIT
    } state_t;

    state_t               state;
    logic [DigW-1:0]      dig_cnt;
    logic [39:0]          tx_buf;
    logic [2:0]           tx_cnt;
    logic                 op_dump;
    logic [3:0]           count_nib;
    logic [8:0]           remaining;
    logic [DataWidth-1:0] rd_data;
    logic                 rd_have;

    logic [3:0]           rx_nib;
    logic                 rx_is_hex;
    logic                 rx_ok;
    logic [7:0]           cnt_next;
    logic [DataWidth-1:0] rd_byte;
    logic [7:0]           rd_hi;
    logic [7:0]           rd_lo;

    function automatic logic [7:0] hex_char(input logic [3:0] n);
        return (n < 4'd10) ? (8'h30 + {4'h0, n}) : (8'h57 + {4'h0, n});
    endfunction

    always_comb begin
        rx_nib    = 4'h0;
        rx_is_hex = 1'b1;
        if (bus.rxByte >= 8'h30 && bus.rxByte <= 8'h39)
            rx_nib = bus.rxByte[3:0];
        else if ((bus.rxByte >= 8'h61 && bus.rxByte <= 8'h66) ||
                 (bus.rxByte >= 8'h41 && bus.rxByte <= 8'h46))
            rx_nib = bus.rxByte[3:0] + 4'd9;
        else
            rx_is_hex = 1'b0;
        // Input is only taken while nothing is queued for TX, so echoes never reorder
        rx_ok = bus.rxValid && (tx_cnt == 3'd0) &&
                (state == S_IDLE || state == S_ADDR || state == S_DATA || state == S_COUNT);
        cnt_next = {count_nib, rx_nib};
        rd_byte  = rd_have ? rd_data : bus.cmdReadData;
        rd_hi    = hex_char(rd_byte[7:4]);
        rd_lo    = hex_char(rd_byte[3:0]);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state            <= S_IDLE;
            dig_cnt          <= '0;
            tx_buf           <= '0;
            tx_cnt           <= '0;
            op_dump          <= 1'b0;
            count_nib        <= '0;
            remaining        <= '0;
            rd_data          <= '0;
            rd_have          <= 1'b0;
            bus.txTrigger    <= 1'b0;
            bus.txByte       <= '0;
            bus.cmdTrigger   <= 1'b0;
            bus.cmdAddr      <= '0;
            bus.cmdWrite     <= 1'b0;
            bus.cmdWriteData <= '0;
        end else begin
            bus.txTrigger <= 1'b0;
            // Drain the TX queue LSB byte first; pushes below only happen when it is empty
            if (tx_cnt != 3'd0 && !bus.txBusy && !bus.txTrigger) begin
                bus.txTrigger <= 1'b1;
                bus.txByte    <= tx_buf[7:0];
                tx_buf        <= tx_buf >> 8;
                tx_cnt        <= tx_cnt - 3'd1;
            end

            case (state)
                S_IDLE: begin
                    if (rx_ok) begin
                        if (bus.rxByte == 8'h77 || bus.rxByte == 8'h72 || bus.rxByte == 8'h64) begin
                            tx_buf       <= {32'h0, bus.rxByte};
                            tx_cnt       <= 3'd1;
                            bus.cmdWrite <= (bus.rxByte == 8'h77);
                            op_dump      <= (bus.rxByte == 8'h64);
                            dig_cnt      <= '0;
                            state        <= S_ADDR;
                        end else begin
                            tx_buf <= {8'h00, 8'h0a, 8'h0d, 8'h3f, bus.rxByte};
                            tx_cnt <= 3'd4;
                        end
                    end
                end

                S_ADDR, S_DATA, S_COUNT: begin
                    if (rx_ok) begin
                        tx_buf <= {32'h0, bus.rxByte};
                        tx_cnt <= 3'd1;
                        if (!rx_is_hex) begin
                            tx_buf <= {8'h00, 8'h0a, 8'h0d, 8'h3f, bus.rxByte};
                            tx_cnt <= 3'd4;
                            state  <= S_IDLE;
                        end else if (state == S_ADDR) begin
                            bus.cmdAddr <= {bus.cmdAddr[AddrWidth-5:0], rx_nib};
                            dig_cnt     <= dig_cnt + DigW'(1);
                            if (dig_cnt == LastDigit) begin
                                dig_cnt <= '0;
                                if (bus.cmdWrite)
                                    state <= S_DATA;
                                else if (op_dump)
                                    state <= S_COUNT;
                                else
                                    state <= S_EXEC;
                            end
                        end else if (state == S_DATA) begin
                            bus.cmdWriteData <= {bus.cmdWriteData[3:0], rx_nib};
                            dig_cnt          <= dig_cnt + DigW'(1);
                            if (dig_cnt == DigW'(1))
                                state <= S_EXEC;
                        end else begin
                            count_nib <= rx_nib;
                            dig_cnt   <= dig_cnt + DigW'(1);
                            if (dig_cnt == DigW'(1)) begin
                                remaining <= (cnt_next == 8'h00) ? 9'd256 : {1'b0, cnt_next};
                                state     <= S_EXEC;
                            end
                        end
                    end
                end

                S_EXEC: begin
                    if (!bus.cmdTrigger) begin
                        if (tx_cnt == 3'd0)
                            bus.cmdTrigger <= 1'b1;
                    end else if (bus.cmdReady) begin
                        bus.cmdTrigger <= 1'b0;
                        if (bus.cmdWrite) begin
                            tx_buf <= {24'h0, 8'h0a, 8'h0d};
                            tx_cnt <= 3'd2;
                            state  <= S_IDLE;
                        end else begin
                            // Data may already be valid in the acceptance cycle
                            rd_have <= bus.cmdReadDataValid;
                            rd_data <= bus.cmdReadData;
                            state   <= S_WAIT;
                        end
                    end
                end

                S_WAIT: begin
                    if (rd_have || bus.cmdReadDataValid) begin
                        rd_have <= 1'b0;
                        if (!op_dump) begin
                            tx_buf <= {8'h00, 8'h0a, 8'h0d, rd_lo, rd_hi};
                            tx_cnt <= 3'd4;
                            state  <= S_IDLE;
                        end else if (remaining > 9'd1) begin
                            tx_buf      <= {16'h0, 8'h20, rd_lo, rd_hi};
                            tx_cnt      <= 3'd3;
                            bus.cmdAddr <= bus.cmdAddr + AddrWidth'(1);
                            remaining   <= remaining - 9'd1;
                            state       <= S_EXEC;
                        end else begin
                            tx_buf <= {8'h0a, 8'h0d, 8'h20, rd_lo, rd_hi};
                            tx_cnt <= 3'd5;
                            state  <= S_IDLE;
                        end
                    end
                end

                default: state <= S_IDLE;
            endcase
        end
    end
endmodule
